sysid_checker: RTL and testbench



---
 rtl/sysid_checker.sv | 109 ++++++++++
 tb/tb_sysid_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// Reads the sysid slave's ID and timestamp words over Avalon-MM and compares them with the build-time values.
// Zero-wait slave: start at cycle N gives reads at N+1/N+2 and done at N+4; a stall limit per read ends the check with error.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd960051513,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1434265302,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_t;

    // The counter holds stalls already seen, so the limit is hit on the stall that would make it TIMEOUT_CYCLES.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        auto_pend;
    logic [15:0] stall_cnt;
    logic        launch;
    logic        stall_expired;

    assign launch        = ((state == IDLE) && (start || auto_pend)) || ((state == DONE) && start);
    assign stall_expired = waitrequest && (stall_cnt == STALL_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            auto_pend       <= AUTO_START;
            stall_cnt       <= '0;
            address         <= 1'b0;
            read            <= 1'b0;
            id_value        <= '0;
            timestamp_value <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            match           <= 1'b0;
            error           <= 1'b0;
        end else if (launch) begin
            state     <= RD_ID;
            auto_pend <= 1'b0;
            stall_cnt <= '0;
            address   <= 1'b0;
            read      <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            match     <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                RD_ID, RD_TS: begin
                    if (!waitrequest) begin
                        stall_cnt <= '0;
                        if (state == RD_ID) begin
                            id_value <= readdata;
                            address  <= 1'b1;
                            state    <= RD_TS;
                        end else begin
                            timestamp_value <= readdata;
                            read            <= 1'b0;
                            address         <= 1'b0;
                            state           <= CHECK;
                        end
                    end else if (stall_expired) begin
                        // Abandon the read; whichever word was not captured keeps its old value.
                        stall_cnt <= '0;
                        read      <= 1'b0;
                        address   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                        match     <= 1'b0;
                        state     <= DONE;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                CHECK: begin
                    match <= (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
                    error <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                IDLE, DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized self-checking bench for sysid_checker with a cycle-level slave and a transaction-level reference model.
module tb_sysid_checker;

    localparam logic [31:0] EID = 32'd960051513;
    localparam logic [31:0] ETS = 32'd1434265302;
    localparam int          TO  = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        address;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;
    logic [31:0] id_value;
    logic [31:0] timestamp_value;
    logic        busy;
    logic        done;
    logic        match;
    logic        error;

    int total = 0;
    int bad = 0;
    logic [31:0] mdl_id = 32'd0;
    logic [31:0] mdl_ts = 32'd0;

    always #5 clock = ~clock;

    sysid_checker #(
        .EXPECTED_ID(EID),
        .EXPECTED_TIMESTAMP(ETS),
        .TIMEOUT_CYCLES(TO),
        .AUTO_START(1'b1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .address(address),
        .read(read),
        .waitrequest(waitrequest),
        .readdata(readdata),
        .id_value(id_value),
        .timestamp_value(timestamp_value),
        .busy(busy),
        .done(done),
        .match(match),
        .error(error)
    );

    // Acts as the slave for one check: s0/s1 are the stall counts for word 0/1, poke re-pulses start at that cycle.
    task automatic run_txn(input bit do_start, input int poke, input int s0, input int s1,
                           input logic [31:0] w0, input logic [31:0] w1,
                           output int done_cyc, output int reads, output int first_rd,
                           output bit hold_ok, output bit busy_ok);
        int cnt;
        int lim;
        bit stalled;
        logic paddr;
        start = do_start;
        waitrequest = 1'b0;
        done_cyc = -1; reads = 0; first_rd = -1; hold_ok = 1'b1; busy_ok = 1'b1;
        cnt = 0; stalled = 1'b0; paddr = 1'b0;
        for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
            @(negedge clock);
            start = (c == poke);
            if (done === 1'b1) begin
                done_cyc = c;
                if (busy !== 1'b0 || read !== 1'b0) busy_ok = 1'b0;
                waitrequest = 1'b0;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (stalled && cnt < TO && (read !== 1'b1 || address !== paddr)) hold_ok = 1'b0;
                if (read === 1'b1) begin
                    reads++;
                    if (first_rd < 0) first_rd = c;
                    lim = (address === 1'b1) ? s1 : s0;
                    if (cnt < lim) begin
                        waitrequest = 1'b1;
                        readdata = $urandom;
                        cnt++;
                        stalled = 1'b1;
                    end else begin
                        waitrequest = 1'b0;
                        readdata = (address === 1'b1) ? w1 : w0;
                        cnt = 0;
                        stalled = 1'b0;
                    end
                    paddr = address;
                end else begin
                    waitrequest = 1'b0;
                    cnt = 0;
                    stalled = 1'b0;
                end
            end
        end
        start = 1'b0;
    endtask

    // Transaction-level model: a read fails once it has seen TO stalls; the check then ends one cycle later.
    task automatic model_txn(input int s0, input int s1, input logic [31:0] w0, input logic [31:0] w1,
                             output int e_done, output int e_reads, output logic e_match, output logic e_err);
        if (s0 >= TO) begin
            e_done = 1 + TO; e_reads = TO; e_err = 1'b1;
        end else if (s1 >= TO) begin
            mdl_id = w0;
            e_done = (s0 + 1) + TO + 1; e_reads = (s0 + 1) + TO; e_err = 1'b1;
        end else begin
            mdl_id = w0; mdl_ts = w1;
            e_done = s0 + s1 + 4; e_reads = s0 + s1 + 2; e_err = 1'b0;
        end
        e_match = !e_err && (mdl_id == EID) && (mdl_ts == ETS);
    endtask

    task automatic test_reset;
        int dc, rd, fr;
        bit ho, bo;
        @(negedge clock);
        @(negedge clock);
        total++; if ({read, busy, done, match, error, address} !== 6'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", {read, busy, done, match, error, address}); end
        total++; if ({id_value, timestamp_value} !== 64'd0) begin bad++; $display("FAIL reset_vals: got %h want 0", {id_value, timestamp_value}); end
        reset_n = 1'b1;
        mdl_id = 0; mdl_ts = 0;
        run_txn(1'b0, 0, 0, 0, EID, ETS, dc, rd, fr, ho, bo);
        total++; if (fr !== 1) begin bad++; $display("FAIL auto_first_read: got %0d want 1", fr); end
        total++; if (rd !== 2) begin bad++; $display("FAIL auto_reads: got %0d want 2", rd); end
        total++; if (dc !== 4) begin bad++; $display("FAIL auto_done_cyc: got %0d want 4", dc); end
        total++; if ({match, error} !== 2'b10) begin bad++; $display("FAIL auto_result: got %b want 10", {match, error}); end
        total++; if (id_value !== EID || timestamp_value !== ETS) begin bad++; $display("FAIL auto_words: got %h %h want %h %h", id_value, timestamp_value, EID, ETS); end
        total++; if (!bo) begin bad++; $display("FAIL auto_busy: got 0 want 1"); end
        mdl_id = EID; mdl_ts = ETS;
    endtask

    task automatic test_bad_ts;
        int dc, rd, fr;
        bit ho, bo;
        run_txn(1'b1, 0, 0, 0, EID, 32'd0, dc, rd, fr, ho, bo);
        total++; if (dc !== 4) begin bad++; $display("FAIL badts_done_cyc: got %0d want 4", dc); end
        total++; if ({match, error} !== 2'b00) begin bad++; $display("FAIL badts_result: got %b want 00", {match, error}); end
        total++; if (timestamp_value !== 32'd0) begin bad++; $display("FAIL badts_ts: got %h want 0", timestamp_value); end
        mdl_id = EID; mdl_ts = 32'd0;
    endtask

    task automatic test_stall3;
        int dc, rd, fr;
        bit ho, bo;
        run_txn(1'b1, 0, 3, 3, EID, ETS, dc, rd, fr, ho, bo);
        total++; if (dc !== 10) begin bad++; $display("FAIL stall3_done_cyc: got %0d want 10", dc); end
        total++; if (!ho) begin bad++; $display("FAIL stall3_hold: got 0 want 1"); end
        total++; if (rd !== 8) begin bad++; $display("FAIL stall3_reads: got %0d want 8", rd); end
        total++; if ({match, error} !== 2'b10) begin bad++; $display("FAIL stall3_result: got %b want 10", {match, error}); end
        mdl_id = EID; mdl_ts = ETS;
    endtask

    task automatic test_timeout_id;
        int dc, rd, fr;
        bit ho, bo;
        run_txn(1'b1, 0, 100, 0, 32'hDEAD_BEEF, 32'h0, dc, rd, fr, ho, bo);
        total++; if (rd !== TO) begin bad++; $display("FAIL tmo_reads: got %0d want %0d", rd, TO); end
        total++; if (dc !== TO + 1) begin bad++; $display("FAIL tmo_done_cyc: got %0d want %0d", dc, TO + 1); end
        total++; if ({match, error} !== 2'b01) begin bad++; $display("FAIL tmo_result: got %b want 01", {match, error}); end
        total++; if (id_value !== EID || timestamp_value !== ETS) begin bad++; $display("FAIL tmo_words_kept: got %h %h want %h %h", id_value, timestamp_value, EID, ETS); end
        total++; if (!bo || !ho) begin bad++; $display("FAIL tmo_busy_hold: got %b%b want 11", bo, ho); end
    endtask

    task automatic test_start_ignored;
        int dc, rd, fr;
        bit ho, bo;
        run_txn(1'b1, 2, 2, 0, EID, ETS, dc, rd, fr, ho, bo);
        total++; if (dc !== 6) begin bad++; $display("FAIL busy_start_done_cyc: got %0d want 6", dc); end
        total++; if (rd !== 4) begin bad++; $display("FAIL busy_start_reads: got %0d want 4", rd); end
        run_txn(1'b1, 0, 0, 0, EID, ETS, dc, rd, fr, ho, bo);
        total++; if (dc !== 4) begin bad++; $display("FAIL restart_done_cyc: got %0d want 4", dc); end
        total++; if ({match, error} !== 2'b10) begin bad++; $display("FAIL restart_result: got %b want 10", {match, error}); end
        mdl_id = EID; mdl_ts = ETS;
    endtask

    task automatic test_random;
        int dc, rd, fr, e_dc, e_rd, s0, s1;
        bit ho, bo;
        logic e_m, e_e;
        logic [31:0] w0, w1;
        for (int i = 0; i < 16; i++) begin
            s0 = $urandom_range(0, 5);
            s1 = $urandom_range(0, 5);
            w0 = ($urandom_range(0, 2) != 0) ? EID : 32'($urandom);
            w1 = ($urandom_range(0, 2) != 0) ? ETS : 32'($urandom);
            run_txn(1'b1, 0, s0, s1, w0, w1, dc, rd, fr, ho, bo);
            model_txn(s0, s1, w0, w1, e_dc, e_rd, e_m, e_e);
            total++; if (dc !== e_dc || rd !== e_rd) begin bad++; $display("FAIL rnd%0d_timing: got done=%0d reads=%0d want done=%0d reads=%0d", i, dc, rd, e_dc, e_rd); end
            total++; if ({match, error} !== {e_m, e_e}) begin bad++; $display("FAIL rnd%0d_result: got %b want %b", i, {match, error}, {e_m, e_e}); end
            total++; if (id_value !== mdl_id || timestamp_value !== mdl_ts) begin bad++; $display("FAIL rnd%0d_words: got %h %h want %h %h", i, id_value, timestamp_value, mdl_id, mdl_ts); end
            total++; if (!ho || !bo) begin bad++; $display("FAIL rnd%0d_hold_busy: got %b%b want 11", i, ho, bo); end
        end
    endtask

    task automatic test_reset_mid;
        int dc, rd, fr;
        bit ho, bo;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitrequest = 1'b0;
        readdata = EID;
        @(negedge clock);
        total++; if ({read, address} !== 2'b11) begin bad++; $display("FAIL mid_in_rd_ts: got %b want 11", {read, address}); end
        waitrequest = 1'b1;
        readdata = ETS;
        #2 reset_n = 1'b0;
        #1;
        total++; if ({read, busy, done, match, error, address, id_value, timestamp_value} !== 70'd0) begin bad++; $display("FAIL mid_async_clear: got %h want 0", {read, busy, done, match, error, address, id_value, timestamp_value}); end
        @(negedge clock);
        waitrequest = 1'b0;
        reset_n = 1'b1;
        run_txn(1'b0, 0, 0, 0, EID, ETS, dc, rd, fr, ho, bo);
        total++; if (dc !== 4 || rd !== 2) begin bad++; $display("FAIL mid_auto_timing: got done=%0d reads=%0d want done=4 reads=2", dc, rd); end
        total++; if ({match, error} !== 2'b10) begin bad++; $display("FAIL mid_auto_result: got %b want 10", {match, error}); end
    endtask

    initial begin
        test_reset();
        test_bad_ts();
        test_stall3();
        test_timeout_id();
        test_start_ignored();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
